// File: rtl/cache_pkg.sv
// Shared D-cache port definitions: request tag fields, tag width and the
// arbiter state encoding. No ports; imported by dcache_port_arbiter.
package cache_pkg;

    localparam int TAG_W = 13;

    // Tag layout: {dir, MEMORY, DATA, 7'b0}
    localparam logic       READ   = 1'b1;
    localparam logic       WRITE  = 1'b0;
    localparam logic [3:0] MEMORY = 4'b0001;
    localparam logic       DATA   = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_WAIT = 3'd5
    } arb_state_t;

    function automatic logic [TAG_W-1:0] make_tag(input logic dir);
        return {dir, MEMORY, DATA, 7'b0};
    endfunction

endpackage

// File: rtl/dcache_port_arbiter.sv
// Shares the single D-cache core port between Memory-stage reads and
// Writeback-stage two-beat writes, with round-robin arbitration on ties and a
// sticky watchdog flag for transactions that stay outstanding too long.
//
// Ports:
//   clk, reset (async, active-low)
//   rd_reqcyc/rd_addr        -> rd_respcyc/rd_data      read side
//   wr_reqcyc/wr_addr/wr_data -> wr_done                write side
//   c_reqcyc/c_req/c_reqtag <- c_reqack                 cache request
//   c_respcyc/c_resp        -> c_respack                cache response
//   timeout_err                                          sticky watchdog flag
//
// state   | meaning
// IDLE    | no transaction, arbitrating
// RD_REQ  | read address presented, waiting for ack
// RD_WAIT | read accepted, waiting for response
// WR_ADDR | write address presented, waiting for ack
// WR_DATA | write data beat (one cycle, no ack)
// WR_WAIT | write issued, waiting for response
module dcache_port_arbiter
    import cache_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_reqcyc,
    input  logic [63:0]       rd_addr,
    output logic              rd_respcyc,
    output logic [63:0]       rd_data,
    input  logic              wr_reqcyc,
    input  logic [63:0]       wr_addr,
    input  logic [63:0]       wr_data,
    output logic              wr_done,
    output logic              c_reqcyc,
    output logic [63:0]       c_req,
    output logic [TAG_W-1:0]  c_reqtag,
    input  logic              c_reqack,
    input  logic              c_respcyc,
    input  logic [63:0]       c_resp,
    output logic              c_respack,
    output logic              timeout_err
);

    localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT);

    arb_state_t        state_q, state_d;
    logic              last_wr_q, last_wr_d;
    logic [9:0]        wd_q, wd_d;
    logic              err_q, err_d;
    logic              c_reqcyc_q, c_reqcyc_d;
    logic [63:0]       c_req_q, c_req_d;
    logic [TAG_W-1:0]  c_reqtag_q, c_reqtag_d;
    logic              rd_respcyc_q, rd_respcyc_d;
    logic [63:0]       rd_data_q, rd_data_d;
    logic              wr_done_q, wr_done_d;
    logic              c_respack_q, c_respack_d;

    logic grant_wr, grant_rd, read_done, write_done;

    // Tie goes to whichever side was not granted last.
    assign grant_wr = wr_reqcyc && (!rd_reqcyc || !last_wr_q);
    assign grant_rd = rd_reqcyc && !grant_wr;

    // A read may finish straight from RD_REQ when ack and response coincide.
    assign read_done  = c_respcyc && ((state_q == RD_WAIT) ||
                                      (state_q == RD_REQ && c_reqack));
    assign write_done = c_respcyc && (state_q == WR_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_wr_q    <= 1'b0;
            wd_q         <= '0;
            err_q        <= 1'b0;
            c_reqcyc_q   <= 1'b0;
            c_req_q      <= '0;
            c_reqtag_q   <= '0;
            rd_respcyc_q <= 1'b0;
            rd_data_q    <= '0;
            wr_done_q    <= 1'b0;
            c_respack_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_wr_q    <= last_wr_d;
            wd_q         <= wd_d;
            err_q        <= err_d;
            c_reqcyc_q   <= c_reqcyc_d;
            c_req_q      <= c_req_d;
            c_reqtag_q   <= c_reqtag_d;
            rd_respcyc_q <= rd_respcyc_d;
            rd_data_q    <= rd_data_d;
            wr_done_q    <= wr_done_d;
            c_respack_q  <= c_respack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_wr)      state_d = WR_ADDR;
                else if (grant_rd) state_d = RD_REQ;
            end
            RD_REQ:  if (c_reqack)  state_d = c_respcyc ? IDLE : RD_WAIT;
            RD_WAIT: if (c_respcyc) state_d = IDLE;
            WR_ADDR: if (c_reqack)  state_d = WR_DATA;
            WR_DATA: state_d = WR_WAIT;
            WR_WAIT: if (c_respcyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        c_reqcyc_d   = (state_d == RD_REQ) || (state_d == WR_ADDR) || (state_d == WR_DATA);
        c_req_d      = c_req_q;
        c_reqtag_d   = c_reqtag_q;
        case (state_d)
            RD_REQ: begin
                c_req_d    = rd_addr;
                c_reqtag_d = make_tag(READ);
            end
            WR_ADDR: begin
                c_req_d    = wr_addr;
                c_reqtag_d = make_tag(WRITE);
            end
            WR_DATA: begin
                c_req_d    = wr_data;
                c_reqtag_d = make_tag(WRITE);
            end
            default: ;
        endcase

        rd_respcyc_d = read_done;
        wr_done_d    = write_done;
        c_respack_d  = read_done || write_done;
        rd_data_d    = read_done ? c_resp : rd_data_q;

        last_wr_d = last_wr_q;
        wd_d      = wd_q;
        err_d     = err_q;
        if (state_q == IDLE) begin
            if (grant_wr || grant_rd) begin
                last_wr_d = grant_wr;
                wd_d      = '0;
            end
        end else if (wd_q != WD_LIMIT) begin
            wd_d = wd_q + 10'd1;
            if (wd_d == WD_LIMIT) err_d = 1'b1;
        end
    end

    assign c_reqcyc    = c_reqcyc_q;
    assign c_req       = c_req_q;
    assign c_reqtag    = c_reqtag_q;
    assign rd_respcyc  = rd_respcyc_q;
    assign rd_data     = rd_data_q;
    assign wr_done     = wr_done_q;
    assign c_respack   = c_respack_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
module tb_dcache_port_arbiter;

    localparam int TB_TO = 8;
    localparam logic [12:0] TAG_RD = 13'h1180;
    localparam logic [12:0] TAG_WR = 13'h0180;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_reqcyc, wr_reqcyc, c_reqack, c_respcyc;
    logic [63:0] rd_addr, wr_addr, wr_data, c_resp;
    logic        rd_respcyc, wr_done, c_reqcyc, c_respack, timeout_err;
    logic [63:0] rd_data, c_req;
    logic [12:0] c_reqtag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.TIMEOUT(TB_TO)) dut (
        .clk(clk), .reset(reset),
        .rd_reqcyc(rd_reqcyc), .rd_addr(rd_addr), .rd_respcyc(rd_respcyc), .rd_data(rd_data),
        .wr_reqcyc(wr_reqcyc), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .c_reqcyc(c_reqcyc), .c_req(c_req), .c_reqtag(c_reqtag), .c_reqack(c_reqack),
        .c_respcyc(c_respcyc), .c_resp(c_resp), .c_respack(c_respack),
        .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transaction, described by its
    // kind and how many of its handshake steps have happened.
    bit          m_busy, m_wr, m_last_wr, m_err;
    int          m_step, m_age;
    logic        e_reqcyc, e_rd_resp, e_wr_done, e_respack;
    logic [63:0] e_req, e_rd_data;
    logic [12:0] e_tag;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_wr = 0; m_last_wr = 0; m_err = 0; m_step = 0; m_age = 0;
            e_reqcyc = 0; e_rd_resp = 0; e_wr_done = 0; e_respack = 0;
            e_req = '0; e_rd_data = '0; e_tag = '0;
        end else begin
            e_rd_resp = 0; e_wr_done = 0; e_respack = 0;
            if (m_busy) begin
                check("req_held", m_wr ? wr_reqcyc : rd_reqcyc, 1'b1);
                m_age = m_age + 1;
                if (m_age >= TB_TO) m_err = 1;
                if (!m_wr) begin
                    if ((m_step == 0 && c_reqack) || m_step == 1) begin
                        if (m_step == 0) e_reqcyc = 0;
                        m_step = 1;
                        if (c_respcyc) begin
                            e_rd_data = c_resp; e_rd_resp = 1; e_respack = 1; m_busy = 0;
                        end
                    end
                end else begin
                    if (m_step == 0 && c_reqack) begin
                        e_req = wr_data; m_step = 1;
                    end else if (m_step == 1) begin
                        e_reqcyc = 0; m_step = 2;
                    end else if (m_step == 2 && c_respcyc) begin
                        e_wr_done = 1; e_respack = 1; m_busy = 0;
                    end
                end
            end else if (rd_reqcyc || wr_reqcyc) begin
                m_wr      = wr_reqcyc && (!rd_reqcyc || !m_last_wr);
                m_last_wr = m_wr;
                m_busy = 1; m_step = 0; m_age = 0;
                e_reqcyc = 1;
                e_req = m_wr ? wr_addr : rd_addr;
                e_tag = m_wr ? TAG_WR : TAG_RD;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("c_reqcyc", c_reqcyc, e_reqcyc);
            check("c_req", c_req, e_req);
            check("c_reqtag", c_reqtag, e_tag);
            check("rd_respcyc", rd_respcyc, e_rd_resp);
            check("rd_data", rd_data, e_rd_data);
            check("wr_done", wr_done, e_wr_done);
            check("c_respack", c_respack, e_respack);
            check("timeout_err", timeout_err, m_err);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_c_reqcyc"}, c_reqcyc, 0);
        check({tag, "_c_req"}, c_req, 0);
        check({tag, "_c_reqtag"}, c_reqtag, 0);
        check({tag, "_rd_respcyc"}, rd_respcyc, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_wr_done"}, wr_done, 0);
        check({tag, "_c_respack"}, c_respack, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #2 reset = 1'b0;
        @(negedge clk); #2 reset = 1'b1;
    endtask

    // Minimal cache: ack the pending request, respond as soon as allowed.
    task automatic serve_one(input int idx, output logic dir);
        bit found = 0;
        dir = 1'bx;
        for (int i = 0; i < 20; i++) begin
            if (c_reqcyc) begin found = 1; break; end
            @(negedge clk);
        end
        check("grant_seen", found, 1);
        if (!found) return;
        dir = c_reqtag[12];
        c_reqack = 1; @(negedge clk); c_reqack = 0;
        if (dir == 1'b0) @(negedge clk);
        c_respcyc = 1; c_resp = 64'hA5A5_0000 + 64'(idx);
        @(negedge clk); c_respcyc = 0;
    endtask

    logic order [4];

    initial begin
        reset = 0; rd_reqcyc = 0; wr_reqcyc = 0; c_reqack = 0; c_respcyc = 0;
        rd_addr = 0; wr_addr = 0; wr_data = 0; c_resp = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        #2 reset = 1;

        // Read only
        @(negedge clk); rd_reqcyc = 1; rd_addr = 64'h1000;
        @(negedge clk);
        check("rd_reqcyc_out", c_reqcyc, 1);
        check("rd_addr_out", c_req, 64'h1000);
        check("rd_tag", c_reqtag, TAG_RD);
        @(negedge clk); c_reqack = 1;
        @(negedge clk); c_reqack = 0;
        check("rd_drop_after_ack", c_reqcyc, 0);
        repeat (2) @(negedge clk);
        c_respcyc = 1; c_resp = 64'hDEADBEEF;
        @(negedge clk); c_respcyc = 0;
        check("rd_pulse", rd_respcyc, 1);
        check("rd_value", rd_data, 64'hDEADBEEF);
        check("rd_respack", c_respack, 1);
        rd_reqcyc = 0;
        @(negedge clk);
        check("rd_pulse_end", rd_respcyc, 0);
        check("rd_hold", rd_data, 64'hDEADBEEF);

        // Write only
        wr_reqcyc = 1; wr_addr = 64'h2000; wr_data = 64'h55;
        @(negedge clk);
        check("wr_addr_beat", c_req, 64'h2000);
        check("wr_tag", c_reqtag, TAG_WR);
        @(negedge clk);
        check("wr_addr_held", c_req, 64'h2000);
        c_reqack = 1;
        @(negedge clk); c_reqack = 0;
        check("wr_data_beat", c_req, 64'h55);
        check("wr_data_valid", c_reqcyc, 1);
        @(negedge clk);
        check("wr_after_beat", c_reqcyc, 0);
        check("wr_req_hold", c_req, 64'h55);
        c_respcyc = 1; c_resp = 64'h1111;
        @(negedge clk); c_respcyc = 0;
        check("wr_done_pulse", wr_done, 1);
        check("wr_rd_data_untouched", rd_data, 64'hDEADBEEF);
        wr_reqcyc = 0;
        @(negedge clk);
        check("wr_done_end", wr_done, 0);

        // Simultaneous requests from reset: W, R, W, R
        do_reset();
        rd_reqcyc = 1; rd_addr = 64'h3000;
        wr_reqcyc = 1; wr_addr = 64'h4000; wr_data = 64'h77;
        for (int i = 0; i < 4; i++) serve_one(i, order[i]);
        rd_reqcyc = 0; wr_reqcyc = 0;
        check("order0", order[0], 0);
        check("order1", order[1], 1);
        check("order2", order[2], 0);
        check("order3", order[3], 1);
        check("order_rd_data", rd_data, 64'hA5A5_0003);

        // Ack and response together on a read: pulse two cycles after request
        @(negedge clk); rd_reqcyc = 1; rd_addr = 64'h6000;
        @(negedge clk);
        c_reqack = 1; c_respcyc = 1; c_resp = 64'h1234;
        @(negedge clk); c_reqack = 0; c_respcyc = 0;
        check("fast_pulse", rd_respcyc, 1);
        check("fast_value", rd_data, 64'h1234);
        check("fast_no_req", c_reqcyc, 0);
        rd_reqcyc = 0;
        @(negedge clk);
        check("fast_no_stray", c_reqcyc, 0);

        // Reset while waiting for a read response
        rd_reqcyc = 1; rd_addr = 64'h7000;
        @(negedge clk); c_reqack = 1;
        @(negedge clk); c_reqack = 0;
        #2 reset = 0;
        #1 check_all_zero("midreset");
        rd_reqcyc = 0;
        @(negedge clk); #2 reset = 1;
        @(negedge clk); c_respcyc = 1; c_resp = 64'hBAD;
        @(negedge clk); c_respcyc = 0;
        check("post_reset_ack", c_respack, 0);
        check("post_reset_pulse", rd_respcyc, 0);
        check("post_reset_data", rd_data, 0);

        // Watchdog: flag 8 cycles after the grant, sticky afterwards
        do_reset();
        rd_reqcyc = 1; rd_addr = 64'h5000;
        @(negedge clk);
        check("to_grant", c_reqcyc, 1);
        repeat (7) @(negedge clk);
        check("to_before", timeout_err, 0);
        @(negedge clk);
        check("to_rise", timeout_err, 1);
        c_reqack = 1;
        @(negedge clk); c_reqack = 0; c_respcyc = 1; c_resp = 64'hC0DE;
        @(negedge clk); c_respcyc = 0;
        check("to_late_pulse", rd_respcyc, 1);
        rd_reqcyc = 0;
        repeat (2) @(negedge clk);
        check("to_sticky", timeout_err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
